// File: rtl/serial_sub32.sv
// Bit-serial subtractor: A - B - Bin, LSB first, one full-adder step per cycle.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.

module serial_sub32_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_c;
  assign o_cout = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_sub32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             Bout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;
  logic             w_accept;

  // Subtraction as A + ~B + ~Bin; r_a doubles as the result shift register.
  serial_sub32_fa u_fa (
    .i_a    (r_a[0]),
    .i_b    (~r_b[0]),
    .i_c    (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = start && (r_state != RUN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_carry <= ~Bin;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= {w_sum, r_a[WIDTH-1:1]};
        r_b     <= {1'b0, r_b[WIDTH-1:1]};
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= {w_sum, r_a[WIDTH-1:1]};
          r_bout <= ~w_cout;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out early, so keep copies for the final flag.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= A[WIDTH-1];
      r_b_msb <= B[WIDTH-1];
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_sum != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign diff = r_diff;
  assign Bout = r_bout;
endmodule

// File: tb/tb_serial_sub32.sv
// Directed bench for serial_sub32: latency, borrow, overflow, back-to-back, ignored start, abort.
// Expected ovf follows SERIAL_SUB_OVF_EN.

module tb_serial_sub32;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         Bout;
  logic         ovf;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  serial_sub32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .Bout  (Bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Steps until done (bounded); ncyc counts cycles sampled before done.
  task automatic wait_run(output int nbusy, output int ncyc, output bit got_done);
    nbusy = 0;
    ncyc = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) nbusy++;
      ncyc++;
      tick();
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    A = a; B = b; Bin = bin; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; A = 32'h1234; B = 32'h1; Bin = 1'b0;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (diff !== '0)   begin n_fail++; $display("FAIL reset_diff got=%h exp=0", diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout got=%b exp=0", Bout); end
    n_cmp++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    start = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    $display("reset: busy=%b done=%b diff=%h", busy, done, diff);
  endtask

  task automatic test_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] ed, input logic eb, input logic eo);
    int nbusy, ncyc;
    bit got;
    issue(a, b, bin);
    wait_run(nbusy, ncyc, got);
    n_cmp++; if (!got)        begin n_fail++; $display("FAIL %s_done_seen got=0 exp=1", name); end
    n_cmp++; if (ncyc != W)   begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, ncyc, W); end
    n_cmp++; if (nbusy != W)  begin n_fail++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, nbusy, W); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_in_done got=%b exp=0", name, busy); end
    n_cmp++; if (diff !== ed) begin n_fail++; $display("FAIL %s_diff got=%h exp=%h", name, diff, ed); end
    n_cmp++; if (Bout !== eb) begin n_fail++; $display("FAIL %s_bout got=%b exp=%b", name, Bout, eb); end
    n_cmp++; if (ovf !== eo)  begin n_fail++; $display("FAIL %s_ovf got=%b exp=%b", name, ovf, eo); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
    n_cmp++; if (diff !== ed) begin n_fail++; $display("FAIL %s_diff_hold got=%h exp=%h", name, diff, ed); end
    $display("%s: A=%h B=%h Bin=%b -> diff=%h Bout=%b ovf=%b cycles=%0d", name, a, b, bin, diff, Bout, ovf, ncyc);
  endtask

  task automatic test_back_to_back;
    int nbusy, ncyc;
    bit got;
    issue(32'd10, 32'd10, 1'b1);
    wait_run(nbusy, ncyc, got);
    n_cmp++; if (!got || ncyc != W) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=%0d", ncyc, W); end
    n_cmp++; if (diff !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_first_diff got=%h exp=ffffffff", diff); end
    n_cmp++; if (Bout !== 1'b1) begin n_fail++; $display("FAIL b2b_first_bout got=%b exp=1", Bout); end
    // start held high during the DONE cycle
    issue(32'd7, 32'd2, 1'b0);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy got=%b exp=1", busy); end
    wait_run(nbusy, ncyc, got);
    n_cmp++; if (!got || ncyc + 1 != W + 1) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=%0d", ncyc + 1, W + 1); end
    n_cmp++; if (diff !== 32'd5) begin n_fail++; $display("FAIL b2b_second_diff got=%h exp=5", diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL b2b_second_bout got=%b exp=0", Bout); end
    $display("back_to_back: second diff=%h Bout=%b after %0d cycles", diff, Bout, ncyc + 1);
    tick();
  endtask

  task automatic test_ignore_start;
    int nbusy, ncyc;
    bit got;
    issue(32'd9, 32'd4, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (diff !== 32'd5) begin n_fail++; $display("FAIL ign_no_partial got=%h exp=5", diff); end
    A = 32'd1; B = 32'd1; Bin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    wait_run(nbusy, ncyc, got);
    n_cmp++; if (!got || 6 + ncyc != W + 1) begin n_fail++; $display("FAIL ign_done_cycle got=%0d exp=%0d", 6 + ncyc, W + 1); end
    n_cmp++; if (diff !== 32'd5) begin n_fail++; $display("FAIL ign_diff got=%h exp=5", diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL ign_bout got=%b exp=0", Bout); end
    $display("ignore_start: diff=%h done_cycle=%0d", diff, 6 + ncyc);
    tick();
  endtask

  task automatic test_abort;
    int ndone;
    issue(32'd9, 32'd4, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
    n_cmp++; if (diff !== '0)   begin n_fail++; $display("FAIL abort_diff got=%h exp=0", diff); end
    n_cmp++; if (Bout !== 1'b0) begin n_fail++; $display("FAIL abort_bout got=%b exp=0", Bout); end
    n_cmp++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL abort_ovf got=%b exp=0", ovf); end
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    n_cmp++; if (ndone != 0) begin n_fail++; $display("FAIL abort_no_activity got=%0d exp=0", ndone); end
    $display("abort: busy=%b diff=%h stray_cycles=%0d", busy, diff, ndone);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    test_reset();
    test_op("basic",  32'd5,         32'd3, 1'b0, 32'd2,         1'b0, 1'b0);
    test_op("borrow", 32'd0,         32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    test_op("ovf",    32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, OVF_ON);
    test_op("bin",    32'd100,       32'd50, 1'b1, 32'd49,       1'b0, 1'b0);
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_op("after_abort", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, OVF_ON);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_sub32.md
SERIAL_SUB32 -- requirements
Module: serial_sub32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only when busy=0.
REQ-005 A  input  WIDTH  minuend; sampled on accepted start.
REQ-006 B  input  WIDTH  subtrahend; sampled on accepted start.
REQ-007 Bin  input  1  borrow-in; sampled on accepted start.
REQ-008 busy  output  1  high while subtraction in progress.
REQ-009 done  output  1  one-cycle pulse; result outputs valid.
REQ-010 diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
REQ-011 Bout  output  1  borrow-out; 1 when A < B + Bin (unsigned).
REQ-012 ovf  output  1  signed (two's complement) overflow flag.

Function
REQ-013 The datapath SHALL compute one bit per cycle with a single one-bit full-adder instance: sum = a_i + ~b_i + c; c initialised to ~Bin; LSB first.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; reset state IDLE.
REQ-015 IDLE -> RUN on start=1; A, B, Bin captured into internal shift registers on that edge; bit counter cleared.
REQ-016 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), one bit per cycle, then -> DONE.
REQ-017 DONE SHALL last one cycle; done=1 only in DONE; DONE -> RUN if start=1 in that cycle (back-to-back), else -> IDLE.
REQ-018 Latency: start accepted at edge k; busy=1 for cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1.
REQ-019 busy SHALL be 1 in RUN only; start while busy=1 SHALL be ignored and operands not resampled.
REQ-020 diff, Bout, ovf SHALL update only on the RUN -> DONE edge and hold until the next completion; no partial results visible.
REQ-021 Bout SHALL equal the inverse of the final full-adder carry.
REQ-022 Changes on A, B, Bin after acceptance SHALL not affect the running operation.

Reset
REQ-023 rst=1 SHALL force IDLE, clear counter and shift registers, and drive busy=0, done=0, diff=0, Bout=0, ovf=0 on the next edge.
REQ-024 rst mid-RUN SHALL abort without producing done; rst has priority over start in the same cycle.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN: when defined, ovf SHALL be computed as (A[MSB] != B[MSB]) and (diff[MSB] != A[MSB]) at completion.
REQ-026 When SERIAL_SUB_OVF_EN is undefined, the ovf port SHALL remain present and be tied to 0; no overflow logic synthesised.

Verification
REQ-027 A=5, B=3, Bin=0, start at edge 0 -> busy cycles 1..32, done at cycle 33, diff=2, Bout=0, ovf=0.
REQ-028 A=0, B=1, Bin=0 -> diff=0xFFFFFFFF, Bout=1, ovf=0.
REQ-029 A=0x80000000, B=1, Bin=0 -> diff=0x7FFFFFFF, Bout=0, ovf=1 with SERIAL_SUB_OVF_EN, 0 without.
REQ-030 A=10, B=10, Bin=1 -> diff=0xFFFFFFFF, Bout=1; then start held high in DONE with A=7, B=2 -> second done 33 cycles later, diff=5.
REQ-031 Start A=9, B=4; at cycle 5 assert start with A=1, B=1 -> ignored, result diff=5; repeat and assert rst at cycle 10 -> busy=0, no done, diff=0, Bout=0, ovf=0.
